// File: rtl/voice_sched_pkg.sv
// Shared encodings and default widths for the voice scheduler block.
package voice_sched_pkg;

    localparam logic [1:0] ACCEPT   = 2'd0;
    localparam logic [1:0] WAIT_ADV = 2'd1;

    localparam int DEFAULT_NOTE_W = 6;
    localparam int DEFAULT_DUR_W  = 6;

    localparam logic [1:0] LEFT  = 2'b10;
    localparam logic [1:0] RIGHT = 2'b01;
    localparam logic [1:0] BOTH  = 2'b11;

endpackage

// File: rtl/voice_scheduler_picker.sv
// Lowest-index-set-bit priority encoder: one-hot grant plus an any-request flag.
module voice_picker #(
    parameter int NUM_VOICES = 3
) (
    input  logic [NUM_VOICES-1:0] req,
    output logic [NUM_VOICES-1:0] grant,
    output logic                  any
);

    // Two's-complement trick isolates the lowest set bit.
    assign grant = req & (~req + NUM_VOICES'(1));
    assign any   = |req;

endmodule

// File: rtl/voice_scheduler.sv
// Dispatches song entries to the lowest idle note_player voice and
// stalls the entry stream for beat-counted time advances.
module voice_scheduler
    import voice_sched_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = DEFAULT_NOTE_W,
    parameter int DUR_W      = DEFAULT_DUR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play_enable,
    input  logic                  beat,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_advance,
    input  logic [NOTE_W-1:0]     in_note,
    input  logic [DUR_W-1:0]      in_duration,
    input  logic [1:0]            in_stereo,
    input  logic [NUM_VOICES-1:0] voice_done,
    output logic [NUM_VOICES-1:0] voice_load,
    output logic [NOTE_W-1:0]     note_out,
    output logic [DUR_W-1:0]      duration_out,
    output logic [1:0]            stereo_out,
    output logic [NUM_VOICES-1:0] voice_busy,
    output logic                  advancing,
    output logic                  all_idle
);

    logic [1:0]            state;
    logic [DUR_W-1:0]      adv_count;
    logic [NUM_VOICES-1:0] free;
    logic [NUM_VOICES-1:0] grant;
    logic [NUM_VOICES-1:0] set_vec;
    logic                  any_free;
    logic                  accept;
    logic                  dispatch;
    logic                  dur_zero;
    logic                  beat_en;

    assign free = ~voice_busy;

    voice_picker #(.NUM_VOICES(NUM_VOICES)) u_picker (
        .req   (free),
        .grant (grant),
        .any   (any_free)
    );

    // Reset gates in_ready so no entry is taken while the registers are held.
    assign in_ready = !reset && (state == ACCEPT) && play_enable
                      && (in_is_advance || any_free);
    assign accept    = in_valid && in_ready;
    assign dur_zero  = (in_duration == '0);
    assign dispatch  = accept && !in_is_advance && !dur_zero;
    assign set_vec   = dispatch ? grant : '0;
    assign beat_en   = beat && play_enable;
    assign advancing = (state == WAIT_ADV);
    assign all_idle  = (state == ACCEPT) && (voice_busy == '0);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACCEPT;
            adv_count <= '0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (accept && in_is_advance && !dur_zero) begin
                        state     <= WAIT_ADV;
                        adv_count <= in_duration;
                    end
                end
                WAIT_ADV: begin
                    if (beat_en && adv_count != '0) begin
                        adv_count <= adv_count - DUR_W'(1);
                        if (adv_count == DUR_W'(1)) begin
                            state <= ACCEPT;
                        end
                    end
                end
                default: begin
                    state     <= ACCEPT;
                    adv_count <= '0;
                end
            endcase
        end
    end

    // Set is OR-ed after the clear mask, so a same-cycle set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            voice_busy <= '0;
            voice_load <= '0;
        end else begin
            voice_busy <= (voice_busy & ~voice_done) | set_vec;
            voice_load <= set_vec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note_out     <= '0;
            duration_out <= '0;
            stereo_out   <= '0;
        end else if (dispatch) begin
            note_out     <= in_note;
            duration_out <= in_duration;
            stereo_out   <= in_stereo;
        end
    end

    a_no_set_clear: assert property (@(posedge clk) disable iff (reset)
        (set_vec & voice_done) == '0);

    a_load_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(voice_load));

    a_stereo_legal: assert property (@(posedge clk) disable iff (reset)
        dispatch |-> (in_stereo == LEFT || in_stereo == RIGHT || in_stereo == BOTH));

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed self-checking bench for voice_scheduler.
module tb_voice_scheduler;
    import voice_sched_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       play_enable;
    logic       beat;
    logic       in_valid;
    logic       in_ready;
    logic       in_is_advance;
    logic [5:0] in_note;
    logic [5:0] in_duration;
    logic [1:0] in_stereo;
    logic [2:0] voice_done;
    logic [2:0] voice_load;
    logic [5:0] note_out;
    logic [5:0] duration_out;
    logic [1:0] stereo_out;
    logic [2:0] voice_busy;
    logic       advancing;
    logic       all_idle;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    voice_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .play_enable   (play_enable),
        .beat          (beat),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_is_advance (in_is_advance),
        .in_note       (in_note),
        .in_duration   (in_duration),
        .in_stereo     (in_stereo),
        .voice_done    (voice_done),
        .voice_load    (voice_load),
        .note_out      (note_out),
        .duration_out  (duration_out),
        .stereo_out    (stereo_out),
        .voice_busy    (voice_busy),
        .advancing     (advancing),
        .all_idle      (all_idle)
    );

    task automatic present(input logic adv, input logic [5:0] note,
                           input logic [5:0] dur, input logic [1:0] st);
        in_valid      = 1'b1;
        in_is_advance = adv;
        in_note       = note;
        in_duration   = dur;
        in_stereo     = st;
    endtask

    task automatic release_voices(input logic [2:0] mask);
        @(negedge clk);
        in_valid   = 1'b0;
        voice_done = mask;
        @(negedge clk);
        voice_done = 3'b000;
    endtask

    task automatic test_reset;
        reset = 1'b1; play_enable = 1'b1; beat = 1'b0; voice_done = 3'b000;
        present(1'b1, 6'd0, 6'd3, BOTH);
        @(negedge clk); #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        n_checks++; if (voice_busy !== 3'b000) begin n_fail++; $display("FAIL reset_busy: got %b want 000", voice_busy); end
        n_checks++; if (voice_load !== 3'b000) begin n_fail++; $display("FAIL reset_load: got %b want 000", voice_load); end
        n_checks++; if ({note_out, duration_out, stereo_out} !== 14'd0) begin n_fail++; $display("FAIL reset_bus: got %0d/%0d/%b want 0", note_out, duration_out, stereo_out); end
        n_checks++; if (advancing !== 1'b0 || all_idle !== 1'b1) begin n_fail++; $display("FAIL reset_flags: adv %b idle %b want 0 1", advancing, all_idle); end
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_note;
        @(negedge clk);
        present(1'b0, 6'd20, 6'd10, BOTH);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++; if (voice_load !== 3'b001) begin n_fail++; $display("FAIL single_load: got %b want 001", voice_load); end
        n_checks++; if (note_out !== 6'd20 || duration_out !== 6'd10 || stereo_out !== BOTH) begin n_fail++; $display("FAIL single_bus: got %0d/%0d/%b want 20/10/11", note_out, duration_out, stereo_out); end
        n_checks++; if (voice_busy !== 3'b001) begin n_fail++; $display("FAIL single_busy: got %b want 001", voice_busy); end
        @(negedge clk); #1;
        n_checks++; if (voice_load !== 3'b000 || note_out !== 6'd20) begin n_fail++; $display("FAIL single_pulse: load %b note %0d want 000 20", voice_load, note_out); end
        release_voices(3'b001);
        #1;
        n_checks++; if (voice_busy !== 3'b000) begin n_fail++; $display("FAIL single_clear: got %b want 000", voice_busy); end
    endtask

    task automatic test_back_to_back;
        logic [2:0] exp_load [3];
        exp_load[0] = 3'b001; exp_load[1] = 3'b010; exp_load[2] = 3'b100;
        @(negedge clk);
        present(1'b0, 6'd1, 6'd5, LEFT);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
            @(negedge clk);
            #1;
            n_checks++; if (voice_load !== exp_load[i]) begin n_fail++; $display("FAIL b2b_load%0d: got %b want %b", i, voice_load, exp_load[i]); end
            if (i < 2) present(1'b0, 6'(i + 2), 6'd5, LEFT);
            else       present(1'b0, 6'd33, 6'd7, RIGHT);
        end
        #1;
        n_checks++; if (in_ready !== 1'b0 || voice_busy !== 3'b111) begin n_fail++; $display("FAIL b2b_stall: ready %b busy %b want 0 111", in_ready, voice_busy); end
        @(negedge clk);
        voice_done = 3'b010;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done_same: got %b want 0", in_ready); end
        @(negedge clk);
        voice_done = 3'b000;
        #1;
        n_checks++; if (in_ready !== 1'b1 || voice_busy !== 3'b101) begin n_fail++; $display("FAIL b2b_freed: ready %b busy %b want 1 101", in_ready, voice_busy); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++; if (voice_load !== 3'b010 || note_out !== 6'd33 || stereo_out !== RIGHT) begin n_fail++; $display("FAIL b2b_4th: load %b note %0d st %b want 010 33 01", voice_load, note_out, stereo_out); end
        n_checks++; if (voice_busy !== 3'b111) begin n_fail++; $display("FAIL b2b_busy: got %b want 111", voice_busy); end
        release_voices(3'b111);
        #1;
        n_checks++; if (voice_busy !== 3'b000 || all_idle !== 1'b1) begin n_fail++; $display("FAIL b2b_clear: busy %b idle %b want 000 1", voice_busy, all_idle); end
    endtask

    task automatic test_advance;
        int beats = 0, idle_cyc = -1, load_cyc = -1, acc_cyc = -1;
        logic [2:0] load_val = 3'b000;
        logic accepted = 1'b0;
        @(negedge clk);
        present(1'b1, 6'd0, 6'd3, BOTH);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL adv_ready: got %b want 1", in_ready); end
        @(negedge clk);
        present(1'b0, 6'd9, 6'd4, LEFT);
        #1;
        n_checks++; if (advancing !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL adv_enter: adv %b ready %b want 1 0", advancing, in_ready); end
        for (int k = 2; k < 40; k++) begin
            @(negedge clk);
            if (accepted) in_valid = 1'b0;
            beat = (k % 8 == 4);
            #1;
            if (voice_load != 3'b000 && load_cyc < 0) begin load_cyc = k; load_val = voice_load; end
            if (!advancing && idle_cyc < 0) idle_cyc = k;
            if (beat && advancing) beats++;
            if (in_valid && in_ready && !accepted) begin accepted = 1'b1; acc_cyc = k; end
        end
        beat = 1'b0;
        n_checks++; if (beats !== 3) begin n_fail++; $display("FAIL adv_beats: got %0d want 3", beats); end
        n_checks++; if (idle_cyc !== 21 || acc_cyc !== 21) begin n_fail++; $display("FAIL adv_return: idle %0d accept %0d want 21 21", idle_cyc, acc_cyc); end
        n_checks++; if (load_cyc !== 22 || load_val !== 3'b001) begin n_fail++; $display("FAIL adv_load: cyc %0d load %b want 22 001", load_cyc, load_val); end
        release_voices(3'b001);
    endtask

    task automatic test_pause;
        int idle_cyc = -1, acc_cyc = -1, pause_ready = 0;
        logic accepted = 1'b0;
        @(negedge clk);
        present(1'b1, 6'd0, 6'd4, BOTH);
        @(negedge clk);
        present(1'b0, 6'd12, 6'd2, RIGHT);
        for (int k = 2; k < 46; k++) begin
            @(negedge clk);
            if (accepted) in_valid = 1'b0;
            play_enable = !(k >= 8 && k < 28);
            beat        = (k % 4 == 2);
            #1;
            if (!play_enable && in_ready) pause_ready++;
            if (!advancing && idle_cyc < 0) idle_cyc = k;
            if (in_valid && in_ready && !accepted) begin accepted = 1'b1; acc_cyc = k; end
        end
        beat = 1'b0; play_enable = 1'b1;
        n_checks++; if (pause_ready !== 0) begin n_fail++; $display("FAIL pause_ready: got %0d ready cycles want 0", pause_ready); end
        n_checks++; if (idle_cyc !== 35 || acc_cyc !== 35) begin n_fail++; $display("FAIL pause_return: idle %0d accept %0d want 35 35", idle_cyc, acc_cyc); end
        release_voices(3'b001);
    endtask

    task automatic test_zero_duration;
        @(negedge clk);
        present(1'b0, 6'd7, 6'd5, LEFT);
        @(negedge clk);
        present(1'b0, 6'd8, 6'd0, RIGHT);
        #1;
        n_checks++; if (in_ready !== 1'b1 || voice_load !== 3'b001) begin n_fail++; $display("FAIL zero_note_ready: ready %b load %b want 1 001", in_ready, voice_load); end
        @(negedge clk);
        present(1'b1, 6'd0, 6'd0, BOTH);
        #1;
        n_checks++; if (in_ready !== 1'b1 || voice_load !== 3'b000 || voice_busy !== 3'b001) begin n_fail++; $display("FAIL zero_note: ready %b load %b busy %b want 1 000 001", in_ready, voice_load, voice_busy); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++; if (voice_load !== 3'b000 || voice_busy !== 3'b001 || advancing !== 1'b0) begin n_fail++; $display("FAIL zero_adv: load %b busy %b adv %b want 000 001 0", voice_load, voice_busy, advancing); end
        n_checks++; if (note_out !== 6'd7 || duration_out !== 6'd5) begin n_fail++; $display("FAIL zero_bus: got %0d/%0d want 7/5", note_out, duration_out); end
    endtask

    task automatic test_reset_mid_advance;
        @(negedge clk);
        present(1'b0, 6'd30, 6'd3, BOTH);
        @(negedge clk);
        present(1'b1, 6'd0, 6'd5, BOTH);
        @(negedge clk);
        present(1'b1, 6'd0, 6'd2, BOTH);
        #1;
        n_checks++; if (advancing !== 1'b1 || voice_busy !== 3'b011) begin n_fail++; $display("FAIL rmid_pre: adv %b busy %b want 1 011", advancing, voice_busy); end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (advancing !== 1'b0 || voice_busy !== 3'b000 || voice_load !== 3'b000) begin n_fail++; $display("FAIL rmid_async: adv %b busy %b load %b want 0 000 000", advancing, voice_busy, voice_load); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready: got %b want 0", in_ready); end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++; if (all_idle !== 1'b1 || note_out !== 6'd0) begin n_fail++; $display("FAIL rmid_idle: idle %b note %0d want 1 0", all_idle, note_out); end
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_back_to_back();
        test_advance();
        test_pause();
        test_zero_duration();
        test_reset_mid_advance();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Sits between the song reader and a bank of NUM_VOICES note_player instances.
- Accepts a stream of song entries over a valid/ready handshake. Each entry is either a note or a time-advance.
- Notes are dispatched to the lowest-index idle voice. Advances stall the stream for a beat-counted duration.
- Tracks per-voice busy state from the done_with_note pulses, which enables polyphonic playback.

Parameters:
- NUM_VOICES, 3, number of note_player instances driven.
- NOTE_W, 6, note index width.
- DUR_W, 6, duration width, in 1/48 s beats.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- play_enable  in  1  high = song running; low = pause.
- beat  in  1  1/48 s strobe, one cycle wide.
- in_valid  in  1  song entry present.
- in_ready  out  1  entry accepted this cycle when in_valid && in_ready.
- in_is_advance  in  1  1 = time-advance entry; 0 = note entry.
- in_note  in  NOTE_W  note index (ignored for advances).
- in_duration  in  DUR_W  note length, or advance length, in beats.
- in_stereo  in  2  one-hot/both stereo side for the note.
- voice_done  in  NUM_VOICES  done_with_note from each note_player.
- voice_load  out  NUM_VOICES  one-hot, one-cycle load_new_note pulse per voice.
- note_out  out  NOTE_W  shared note_to_load bus.
- duration_out  out  DUR_W  shared duration_to_load bus.
- stereo_out  out  2  shared stereo_side_to_load bus.
- voice_busy  out  NUM_VOICES  registered busy vector.
- advancing  out  1  high while in the WAIT_ADV state.
- all_idle  out  1  high when the state is ACCEPT and voice_busy == 0.

Behaviour:
- Reset (asynchronous, any cycle, including mid-advance):
  - state = ACCEPT, adv_count = 0, voice_busy = 0, voice_load = 0.
  - note_out, duration_out and stereo_out = 0.
  - in_ready deasserts immediately.
- States: ACCEPT (2'd0) and WAIT_ADV (2'd1). All other codes go to ACCEPT.
- in_ready is combinational. It is 1 only when all of the following hold:
  - state == ACCEPT;
  - play_enable == 1;
  - in_is_advance || (free vector != 0), where free = ~voice_busy.
- Note accept at cycle T, with in_duration != 0:
  - The chosen voice v is the lowest-index bit of free, sampled at T.
  - At the T+1 edge: voice_load[v] = 1 for exactly one cycle; busy[v] = 1.
  - note_out, duration_out and stereo_out take the entry fields. They hold until the next dispatch.
- Note accept with in_duration == 0: the entry is consumed. No load pulse, no busy change.
- Advance accept with in_duration == 0: the entry is consumed and the state stays ACCEPT.
- Advance accept with in_duration = D > 0:
  - state goes to WAIT_ADV and adv_count = D.
  - In WAIT_ADV, adv_count decrements on each cycle where beat && play_enable.
  - When beat && play_enable && adv_count == 1: adv_count goes to 0 and the state goes to ACCEPT. Net wait is exactly D enabled beats.
  - Beats arriving while play_enable == 0 are ignored, so the count freezes.
- Busy clear: busy[i] clears on the edge after voice_done[i] == 1.
  - A voice whose done pulse is in cycle T is still treated as busy for allocation in cycle T. Its free status is visible from T+1.
  - Set has priority over clear for the same bit. This cannot occur legally and is asserted in simulation.
- All voices busy with a note pending: in_ready = 0 and the entry stalls. The entry is dispatched in the first cycle after any busy bit clears.
- voice_done on a voice that is not busy: ignored.
- play_enable low: no accepts. Existing voices pause themselves through their own play_enable input; busy bits are unchanged.
- Width rules:
  - adv_count is DUR_W bits with no wrap.
  - Decrement happens only when adv_count >= 1.
  - voice_load is at most one-hot in every cycle.

Decomposition:
- Package voice_sched_pkg holds:
  - the state encodings ACCEPT and WAIT_ADV;
  - the NOTE_W and DUR_W defaults;
  - the stereo encodings LEFT = 2'b10, RIGHT = 2'b01, BOTH = 2'b11.
- One sub-module, voice_picker: a combinational lowest-index-set-bit priority encoder. It takes NUM_VOICES bits and outputs a one-hot grant plus an any bit.
- State, counter and busy registers use the team's asynchronous-reset flop cells.

Test Plan:
1. After reset, present a note (note = 6'd20, dur = 6'd10, stereo = 2'b11) with play_enable = 1 → in_ready = 1 in the same cycle. The next cycle shows voice_load = 3'b001, note_out = 20, duration_out = 10, voice_busy = 3'b001.
2. Present 4 back-to-back notes with no voice_done → loads go to 3'b001, 3'b010, 3'b100. The 4th entry stalls (in_ready = 0). Pulse voice_done[1] → the 4th note loads onto voice 1 exactly 2 cycles after the done pulse.
3. Advance with D = 3, then a note; beats every 8 cycles → advancing stays high across exactly 3 beats. The note loads 1 cycle after the 3rd beat accept-return.
4. Advance with D = 4; drop play_enable after 2 beats for 5 beats, then restore it → in_ready stays 0 throughout the pause. The state returns to ACCEPT only after 2 further enabled beats.
5. Note with dur = 0 and advance with dur = 0 → both consumed in consecutive cycles, voice_load stays 0, voice_busy is unchanged.
6. Assert reset mid-WAIT_ADV with voice_busy = 3'b011 → advancing, voice_busy and voice_load go to 0 asynchronously. all_idle = 1 after reset releases.
